bn_scheduler: RTL and testbench

- Time-multiplexes one combinational batch_normalization datapath across N_NEURONS neurons.
- Holds a per-neuron BN configuration register file (factor, addend), loaded through a valid/ready config port.
- On each start pulse, sweeps all neurons in index order. Drives the shared datapath one neuron per cycle and registers each saturated result into a packed output vector.
- Sits between the neuron membrane/synapse state and the shared BN instance.

---
 rtl/bn_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_bn_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_scheduler.sv
// bn_scheduler
//
// Shares one combinational batch-normalisation datapath across N_NEURONS
// neurons. Each neuron has a (factor, addend) entry in a small register file
// that is loaded through a valid/ready config port. A start pulse sweeps the
// neurons in index order, one neuron per cycle. Each saturated datapath result
// is registered into its slice of the packed u_next_all vector.
//
// Optional build macro:
//   BN_CFG_CHECK_EN - when defined, the config port rejects factor codes
//                     0000/0111/1011/1111, and rejects x8 (0011) with a
//                     non-zero addend. A rejected write leaves the entry
//                     unchanged and pulses cfg_err.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   config write handshake (ready = !busy)
//   cfg_idx               target neuron of the config write
//   cfg_factor            BN factor code
//   cfg_addend            signed BN addend
//   cfg_err               one-cycle pulse: the accepted write was dropped
//   start                 one-cycle pulse that begins a sweep (ignored unless idle)
//   u_all, z_all          packed signed membrane / synaptic inputs, neuron i at [i*WIDTH +: WIDTH]
//   bn_u, bn_z            datapath operands for the current neuron
//   bn_factor, bn_addend  datapath coefficients for the current neuron
//   bn_u_out              datapath result (combinational from bn_*)
//   u_next_all            registered per-neuron results
//   busy                  sweep in progress
//   done                  one-cycle pulse when u_next_all is complete

module bn_scheduler #(
  parameter int WIDTH        = 6,
  parameter int ADDEND_WIDTH = WIDTH - 1,
  parameter int N_NEURONS    = 4,
  parameter int IDX_W        = $clog2(N_NEURONS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [IDX_W-1:0]               cfg_idx,
  input  logic [3:0]                     cfg_factor,
  input  logic signed [ADDEND_WIDTH-1:0] cfg_addend,
  output logic                           cfg_err,
  input  logic                           start,
  input  logic [N_NEURONS*WIDTH-1:0]     u_all,
  input  logic [N_NEURONS*WIDTH-1:0]     z_all,
  output logic signed [WIDTH-1:0]        bn_u,
  output logic signed [WIDTH-1:0]        bn_z,
  output logic [3:0]                     bn_factor,
  output logic signed [ADDEND_WIDTH-1:0] bn_addend,
  input  logic signed [WIDTH-1:0]        bn_u_out,
  output logic [N_NEURONS*WIDTH-1:0]     u_next_all,
  output logic                           busy,
  output logic                           done
);

  localparam logic [3:0] FACTOR_ONE = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q;
  logic [3:0]                     factor_q [N_NEURONS];
  logic signed [ADDEND_WIDTH-1:0] addend_q [N_NEURONS];
  logic [N_NEURONS*WIDTH-1:0]     u_next_q;
  logic                           cfg_err_q;

  logic cfg_fire;
  logic idx_oob;
  logic cfg_illegal;
  logic cfg_store;
  logic cfg_reject;
  logic last_idx;

  // Config write qualification
  always_comb begin
    cfg_fire = cfg_valid && cfg_ready;
    // Widen before comparing so non-power-of-two neuron counts are caught.
    idx_oob  = (32'(cfg_idx) >= 32'(N_NEURONS));
`ifdef BN_CFG_CHECK_EN
    cfg_illegal = (cfg_factor == 4'b0000) || (cfg_factor == 4'b0111) ||
                  (cfg_factor == 4'b1011) || (cfg_factor == 4'b1111) ||
                  ((cfg_factor == 4'b0011) && (cfg_addend != '0));
`else
    cfg_illegal = 1'b0;
`endif
    cfg_store  = cfg_fire && !idx_oob && !cfg_illegal;
    cfg_reject = cfg_fire && (idx_oob || cfg_illegal);
    last_idx   = (idx_q == IDX_W'(N_NEURONS - 1));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_idx) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, including the operand mux onto the shared datapath
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    bn_u      = '0;
    bn_z      = '0;
    bn_factor = '0;
    bn_addend = '0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          bn_u      = u_all[i*WIDTH +: WIDTH];
          bn_z      = z_all[i*WIDTH +: WIDTH];
          bn_factor = factor_q[i];
          bn_addend = addend_q[i];
        end
      end
    end
  end

  assign cfg_ready  = !busy;
  assign cfg_err    = cfg_err_q;
  assign u_next_all = u_next_q;

  // Sweep index and rejected-write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_reject;
      if (state_q == S_RUN) begin
        idx_q <= last_idx ? '0 : idx_q + 1'b1;
      end else begin
        idx_q <= '0;
      end
    end
  end

  // Config register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        factor_q[i] <= FACTOR_ONE;
        addend_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (cfg_store && (cfg_idx == IDX_W'(i))) begin
          factor_q[i] <= cfg_factor;
          addend_q[i] <= cfg_addend;
        end
      end
    end
  end

  // Result capture: datapath output -> slice of u_next_all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_next_q <= '0;
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          u_next_q[i*WIDTH +: WIDTH] <= bn_u_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_bn_scheduler.sv
// Testbench for bn_scheduler: randomized sweeps and config writes checked
// against a behavioural model of the neuron configuration table and results.
// The shared datapath is modelled as saturating u + z + addend.

module tb_bn_scheduler;

  localparam int WIDTH        = 6;
  localparam int ADDEND_WIDTH = WIDTH - 1;
  localparam int N            = 4;
  localparam int IDX_W        = 2;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           cfg_valid = 1'b0;
  logic                           cfg_ready;
  logic [IDX_W-1:0]               cfg_idx = '0;
  logic [3:0]                     cfg_factor = '0;
  logic signed [ADDEND_WIDTH-1:0] cfg_addend = '0;
  logic                           cfg_err;
  logic                           start = 1'b0;
  logic [N*WIDTH-1:0]             u_all = '0;
  logic [N*WIDTH-1:0]             z_all = '0;
  logic signed [WIDTH-1:0]        bn_u;
  logic signed [WIDTH-1:0]        bn_z;
  logic [3:0]                     bn_factor;
  logic signed [ADDEND_WIDTH-1:0] bn_addend;
  logic signed [WIDTH-1:0]        bn_u_out;
  logic [N*WIDTH-1:0]             u_next_all;
  logic                           busy;
  logic                           done;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int mu[N], mz[N], mf[N], ma[N], mnext[N];

  bn_scheduler #(
    .WIDTH(WIDTH), .ADDEND_WIDTH(ADDEND_WIDTH), .N_NEURONS(N), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_factor(cfg_factor), .cfg_addend(cfg_addend), .cfg_err(cfg_err),
    .start(start), .u_all(u_all), .z_all(z_all),
    .bn_u(bn_u), .bn_z(bn_z), .bn_factor(bn_factor), .bn_addend(bn_addend),
    .bn_u_out(bn_u_out), .u_next_all(u_next_all), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    int hi, lo;
    hi = (1 << (WIDTH - 1)) - 1;
    lo = -(1 << (WIDTH - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Shared datapath stand-in
  always_comb bn_u_out = WIDTH'(sat(int'(bn_u) + int'(bn_z) + int'(bn_addend)));

  function automatic bit model_legal(input int f, input int a);
`ifdef BN_CFG_CHECK_EN
    if (f == 0 || f == 7 || f == 11 || f == 15) return 1'b0;
    if (f == 3 && a != 0) return 1'b0;
    return 1'b1;
`else
    return (f >= 0) || (a >= 0) || 1'b1;
`endif
  endfunction

  function automatic logic [N*WIDTH-1:0] pack_next();
    logic [N*WIDTH-1:0] r;
    for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = WIDTH'(mnext[i]);
    return r;
  endfunction

  function automatic int slice_out(input int i);
    logic signed [WIDTH-1:0] s;
    s = u_next_all[i*WIDTH +: WIDTH];
    return int'(s);
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mf[i] = 4; ma[i] = 0; mnext[i] = 0;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      u_all[i*WIDTH +: WIDTH] = WIDTH'(mu[i]);
      z_all[i*WIDTH +: WIDTH] = WIDTH'(mz[i]);
    end
  endtask

  task automatic set_cfg(input int ci, input int cf, input int ca);
    cfg_idx    = IDX_W'(ci);
    cfg_factor = 4'(cf);
    cfg_addend = ADDEND_WIDTH'(ca);
    cfg_valid  = 1'b1;
  endtask

  task automatic model_write(input int ci, input int cf, input int ca);
    bit ok;
    ok = (ci < N) && model_legal(cf, ca);
    if (ok) begin
      mf[ci] = cf; ma[ci] = ca;
    end
    chk("cfg_err_pulse", longint'(cfg_err), longint'(!ok));
  endtask

  // Idle-time config write; checks the err pulse and its clearing.
  task automatic cfg_write(input int ci, input int cf, input int ca);
    set_cfg(ci, cf, ca);
    chk("cfg_ready_idle", longint'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    model_write(ci, cf, ca);
    tick();
    chk("cfg_err_clear", longint'(cfg_err), 0);
  endtask

  // One sweep. cmode: 0 none, 1 config write held during RUN, 2 config
  // write in the same cycle as start. noise: extra start pulses in RUN/DONE.
  task automatic sweep(input int cmode, input int ci, input int cf, input int ca, input bit noise);
    drive_inputs();
    start = 1'b1;
    if (cmode == 2) set_cfg(ci, cf, ca);
    tick();
    start = 1'b0;
    if (cmode == 2) begin
      cfg_valid = 1'b0;
      model_write(ci, cf, ca);
    end
    for (int k = 0; k < N; k++) begin
      chk("busy_run", longint'(busy), 1);
      chk("done_run", longint'(done), 0);
      chk("cfg_ready_run", longint'(cfg_ready), 0);
      chk($sformatf("bn_u[%0d]", k), longint'(bn_u), longint'(mu[k]));
      chk($sformatf("bn_z[%0d]", k), longint'(bn_z), longint'(mz[k]));
      chk($sformatf("bn_factor[%0d]", k), longint'(bn_factor), longint'(mf[k]));
      chk($sformatf("bn_addend[%0d]", k), longint'(bn_addend), longint'(ma[k]));
      chk("u_next_partial", longint'(u_next_all), longint'(pack_next()));
      mnext[k] = sat(mu[k] + mz[k] + ma[k]);
      if (cmode == 1 && k == 0) set_cfg(ci, cf, ca);
      start = (noise && k == 1);
      tick();
    end
    start = 1'b0;
    chk("done_pulse", longint'(done), 1);
    chk("busy_done", longint'(busy), 0);
    chk("u_next_all", longint'(u_next_all), longint'(pack_next()));
    if (cmode == 1) chk("cfg_ready_done", longint'(cfg_ready), 1);
    if (noise) start = 1'b1;
    tick();
    start = 1'b0;
    if (cmode == 1) begin
      cfg_valid = 1'b0;
      model_write(ci, cf, ca);
    end
    chk("done_clear", longint'(done), 0);
    chk("busy_idle", longint'(busy), 0);
    chk("bn_u_idle", longint'(bn_u), 0);
    tick();
    chk("busy_no_restart", longint'(busy), 0);
    chk("done_single", longint'(done), 0);
  endtask

  initial begin
    model_reset();
    // Reset state
    tick();
    tick();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_cfg_err", longint'(cfg_err), 0);
    chk("rst_u_next", longint'(u_next_all), 0);
    chk("rst_bn_u", longint'(bn_u), 0);
    chk("rst_bn_factor", longint'(bn_factor), 0);
    chk("rst_cfg_ready", longint'(cfg_ready), 1);
    rst_n = 1'b1;
    tick();

    // Directed sweep with default config
    mu = '{10, -3, 31, 0};
    mz = '{5, 2, 1, -32};
    sweep(0, 0, 0, 0, 1'b0);
    chk("dir_s0", slice_out(0), 15);
    chk("dir_s1", slice_out(1), -1);
    chk("dir_s2", slice_out(2), 31);
    chk("dir_s3", slice_out(3), -32);

    // Addend -8 on neuron 2
    cfg_write(2, 4, -8);
    sweep(0, 0, 0, 0, 1'b0);
    chk("dir_addend_s2", slice_out(2), 24);

    // Config write stalled by a running sweep, plus ignored start pulses
    sweep(1, 1, 5, 3, 1'b1);
    sweep(0, 0, 0, 0, 1'b0);
    chk("stalled_write_s1", slice_out(1), sat(-3 + 2 + 3));

    // Config write together with start: the sweep sees the new entry
    sweep(2, 0, 6, -5, 1'b0);
    chk("same_cycle_s0", slice_out(0), 10);

`ifdef BN_CFG_CHECK_EN
    cfg_write(3, 7, 0);
    cfg_write(3, 3, 1);
    cfg_write(3, 3, 0);
    sweep(0, 0, 0, 0, 1'b0);
`endif

    // Randomized sweeps and writes
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++) begin
        mu[i] = int'($urandom_range(0, 63)) - 32;
        mz[i] = int'($urandom_range(0, 63)) - 32;
      end
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 31)) - 16);
      sweep(int'($urandom_range(0, 2)), int'($urandom_range(0, N - 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 31)) - 16,
            1'($urandom_range(0, 1)));
    end

    // Reset during RUN cycle 2
    drive_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_u_next", longint'(u_next_all), 0);
    chk("midrst_bn_u", longint'(bn_u), 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < N + 2; c++) begin
      tick();
      chk("postrst_no_done", longint'(done), 0);
    end
    sweep(0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
